motor_passo_ram_arbiter: RTL and testbench
==========================================

// Module: motor_passo_ram_arbiter
// PURPOSE
//  - Shares one single-port on-chip RAM (32-bit data, 15-bit word address, byte enables) between two Avalon-MM requesters.
//    - Port 0 is the HPS/Nios control path.
//    - Port 1 is the stepper step-profile fetch engine.
//  - Sits between the two requesters and the RAM s1 port; the RAM sees a single master.
//  - Arbitration is round-robin with a bounded hold (burst) window.
//  - Reads are tagged per port, so each port receives its own readdatavalid.
// PARAMETERS
//  ADDR_W        15  RAM word-address width
//  DATA_W        32  RAM data width; byte-enable width = DATA_W/8
//  RD_LATENCY     1  cycles from accepted read to RAM q valid (1 = unregistered q, 2 = registered q)
//  MAX_HOLD       4  max consecutive beats one port keeps the grant while the other port is requesting
// PORTS
//  clk              in   1          system clock
//  reset            in   1          asynchronous, active-high reset
//  m0_address       in   ADDR_W     port 0 word address
//  m0_read          in   1          port 0 read request
//  m0_write         in   1          port 0 write request
//  m0_byteenable    in   DATA_W/8   port 0 byte lanes
//  m0_writedata     in   DATA_W     port 0 write data
//  m0_waitrequest   out  1          port 0 stall
//  m0_readdata      out  DATA_W     port 0 read data
//  m0_readdatavalid out  1          port 0 read data valid
//  m1_*             -    -          same set as m0_*, for port 1
//  ram_address      out  ADDR_W     to RAM address
//  ram_byteenable   out  DATA_W/8   to RAM byteenable
//  ram_chipselect   out  1          to RAM chipselect
//  ram_write        out  1          to RAM write
//  ram_writedata    out  DATA_W     to RAM writedata
//  ram_clken        out  1          to RAM clken; tied 1
//  ram_readdata     in   DATA_W     from RAM readdata
// BEHAVIOUR
//  - Requests and grant
//    - reqN = mN_read | mN_write.
//    - If mN_read and mN_write are both high, the beat is a write; the read is ignored.
//    - grant is combinational from req0, req1 and registered state: last_q (last granted port) and hold_q (beats held).
//  - Grant rules, evaluated each cycle
//    - Only one port requesting: that port is granted.
//    - Both requesting, owner = last_q, hold_q < MAX_HOLD-1: owner keeps the grant and hold_q increments.
//    - Both requesting, hold_q == MAX_HOLD-1: the other port is granted and hold_q clears.
//    - Neither requesting: no grant, last_q holds, hold_q clears.
//    - A grant switching to a new port sets hold_q = 0.
//  - Waitrequest and acceptance
//    - mN_waitrequest = reqN & ~grantN. It is 0 when reqN is 0.
//    - A beat is accepted when reqN & ~mN_waitrequest; there are no extra wait states.
//  - RAM drive (combinational from the granted port)
//    - ram_chipselect = any grant.
//    - ram_write = granted port's write.
//    - ram_address, ram_byteenable, ram_writedata = granted port's values.
//    - With no grant: all RAM outputs 0, except ram_clken = 1.
//  - Read return
//    - Each accepted read pushes a one-hot port tag into an RD_LATENCY-deep shift pipe.
//    - mN_readdatavalid = pipe output bit N, so valid is asserted exactly RD_LATENCY cycles after acceptance.
//    - m0_readdata = m1_readdata = ram_readdata (broadcast); each port qualifies with its own valid.
//    - Back-to-back reads from alternating ports return in issue order, one per cycle.
//    - Full throughput: 1 beat/cycle.
//  - Reset values
//    - last_q = 1, so port 0 wins the first contention.
//    - hold_q = 0.
//    - Tag pipe cleared; both readdatavalid = 0.
//    - Reset asserted mid-transaction: in-flight reads are discarded and no readdatavalid is produced for them after reset.
//    - Reset has no effect on RAM contents.
// STRUCTURE
//  - Package motor_passo_mem_pkg: ADDR_W/DATA_W defaults and a port-id enum {PORT0, PORT1}.
//  - Sub-module motor_passo_rdv_pipe: RD_LATENCY-deep 2-bit tag shift register with async reset.
//  - Grant logic, hold counter and RAM muxing stay in this top level.
// TESTING
//  - Reset, then idle -> all ram_* = 0 (ram_clken = 1), both waitrequest = 0, both readdatavalid = 0.
//  - m0 writes 0xDEADBEEF to address 0x0010 with byteenable 0xF; then m1 reads 0x0010 -> m1_readdatavalid one cycle after acceptance (RD_LATENCY = 1) with data 0xDEADBEEF; m0_readdatavalid stays 0.
//  - Both ports read continuously for 12 cycles, MAX_HOLD = 4 -> grants 0,0,0,0,1,1,1,1,0,0,0,0; no cycle without an accepted beat.
//  - Byte-enable write of 0x000000AA with byteenable 4'b0001 onto 0x11223344 -> readback 0x112233AA.
//  - m0 issues read and write together to 0x0020 with writedata 0x5 -> location written; no m0_readdatavalid.
//  - Read accepted, reset asserted in the next cycle -> no readdatavalid on either port; first post-reset contention is granted to port 0.

Source files
------------

// File: rtl/motor_passo_mem_pkg.sv
// Shared definitions for the stepper-controller RAM arbiter.
// Bus widths and the requester port identifiers.
package motor_passo_mem_pkg;

  localparam int MP_ADDR_W = 15;
  localparam int MP_DATA_W = 32;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  function automatic port_e other_port(input port_e p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/motor_passo_rdv_pipe.sv
// Read-return tag pipe: one-hot port tag per accepted read,
// delayed to line up with the RAM read data.
module motor_passo_rdv_pipe #(
  parameter int LAT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] i_tag,
  output logic [1:0] o_tag
);

  logic [1:0] r_pipe [LAT];

  // Shift tags forward; reset drops every in-flight read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < LAT; i++) r_pipe[i] <= '0;
    end else begin
      r_pipe[0] <= i_tag;
      for (int i = 1; i < LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_tag = r_pipe[LAT-1];

endmodule

// File: rtl/motor_passo_ram_arbiter.sv
// Two-requester Avalon-MM arbiter in front of a single-port RAM.
// Round-robin with a bounded burst window; per-port read valids.
module motor_passo_ram_arbiter
  import motor_passo_mem_pkg::*;
#(
  parameter int ADDR_W     = MP_ADDR_W,
  parameter int DATA_W     = MP_DATA_W,
  parameter int RD_LATENCY = 1,
  parameter int MAX_HOLD   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   ram_address,
  output logic [DATA_W/8-1:0] ram_byteenable,
  output logic                ram_chipselect,
  output logic                ram_write,
  output logic [DATA_W-1:0]   ram_writedata,
  output logic                ram_clken,
  input  logic [DATA_W-1:0]   ram_readdata
);

  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  port_e          r_last;
  logic [HW-1:0]  r_hold;
  logic           r_act;

  logic           w_req0;
  logic           w_req1;
  logic           w_any;
  logic           w_keep;
  logic           w_same;
  port_e          w_sel;
  logic           w_gnt0;
  logic           w_gnt1;
  port_e          w_last_n;
  logic [HW-1:0]  w_hold_n;
  logic [1:0]     w_tag;
  logic [1:0]     w_rdv;

  // Grant: a lone requester wins; under contention the current
  // owner keeps its burst until the window closes, else rotate.
  always_comb begin
    w_req0 = m0_read | m0_write;
    w_req1 = m1_read | m1_write;
    w_any  = w_req0 | w_req1;
    w_keep = r_act & (r_hold != HOLD_LAST);
    w_sel  = PORT0;
    unique case ({w_req1, w_req0})
      2'b01:   w_sel = PORT0;
      2'b10:   w_sel = PORT1;
      2'b11:   w_sel = w_keep ? r_last : other_port(r_last);
      default: w_sel = PORT0;
    endcase
    w_gnt0 = w_any & (w_sel == PORT0);
    w_gnt1 = w_any & (w_sel == PORT1);
  end

  // Next owner and burst length; a fresh or switched grant restarts at 0.
  always_comb begin
    w_same   = r_act & (w_sel == r_last);
    w_last_n = r_last;
    w_hold_n = '0;
    if (w_any) begin
      w_last_n = w_sel;
      if (w_same) begin
        w_hold_n = (r_hold == HOLD_LAST) ? r_hold : r_hold + 1'b1;
      end
    end
  end

  // Arbiter state; port 1 marked as last so port 0 wins first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_last <= PORT1;
      r_hold <= '0;
      r_act  <= 1'b0;
    end else begin
      r_last <= w_last_n;
      r_hold <= w_hold_n;
      r_act  <= w_any;
    end
  end

  // RAM drive from the granted port; quiet bus when idle.
  always_comb begin
    ram_chipselect = w_any;
    ram_write      = 1'b0;
    ram_address    = '0;
    ram_byteenable = '0;
    ram_writedata  = '0;
    if (w_gnt1) begin
      ram_write      = m1_write;
      ram_address    = m1_address;
      ram_byteenable = m1_byteenable;
      ram_writedata  = m1_writedata;
    end else if (w_gnt0) begin
      ram_write      = m0_write;
      ram_address    = m0_address;
      ram_byteenable = m0_byteenable;
      ram_writedata  = m0_writedata;
    end
  end

  assign ram_clken      = 1'b1;
  assign m0_waitrequest = w_req0 & ~w_gnt0;
  assign m1_waitrequest = w_req1 & ~w_gnt1;

  // A beat with both read and write set is a write: no tag.
  assign w_tag = {w_gnt1 & m1_read & ~m1_write,
                  w_gnt0 & m0_read & ~m0_write};

  motor_passo_rdv_pipe #(
    .LAT (RD_LATENCY)
  ) u_rdv_pipe (
    .clk   (clk),
    .reset (reset),
    .i_tag (w_tag),
    .o_tag (w_rdv)
  );

  assign m0_readdatavalid = w_rdv[0];
  assign m1_readdatavalid = w_rdv[1];
  assign m0_readdata      = ram_readdata;
  assign m1_readdata      = ram_readdata;

endmodule

// File: tb/tb_motor_passo_ram_arbiter.sv
// Scoreboard bench for the RAM arbiter: reference arbiter and
// memory model predict grants and read returns.
module tb_motor_passo_ram_arbiter;

  localparam int AW  = 15;
  localparam int DW  = 32;
  localparam int BW  = 4;
  localparam int LAT = 1;
  localparam int MH  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] m0_address, m1_address;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] ram_address;
  logic [BW-1:0] ram_byteenable;
  logic          ram_chipselect, ram_write, ram_clken;
  logic [DW-1:0] ram_writedata;
  logic [DW-1:0] ram_readdata;

  motor_passo_ram_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(LAT), .MAX_HOLD(MH)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
    .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
    .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
    .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
    .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
    .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
    .m1_readdatavalid(m1_readdatavalid),
    .ram_address(ram_address), .ram_byteenable(ram_byteenable),
    .ram_chipselect(ram_chipselect), .ram_write(ram_write),
    .ram_writedata(ram_writedata), .ram_clken(ram_clken),
    .ram_readdata(ram_readdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at cycle %0d", nm, a, e, cyc);
    end
  endfunction

  function automatic logic [31:0] merge(logic [31:0] o, logic [31:0] d,
                                        logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // RAM behavioural model: registered address, 1-cycle read data.
  logic [31:0] mem [int];
  always @(posedge clk) begin
    logic [31:0] o;
    o = mem.exists(int'(ram_address)) ? mem[int'(ram_address)] : 32'h0;
    if (ram_chipselect && ram_write)
      mem[int'(ram_address)] = merge(o, ram_writedata, ram_byteenable);
    else if (ram_chipselect)
      ram_readdata <= o;
  end

  always @(posedge clk) cyc++;

  // Reference state: burst owner, burst length, activity last cycle.
  typedef struct { int due; logic [31:0] data; } exp_t;
  exp_t exp0[$];
  exp_t exp1[$];
  logic [31:0] refm [int];
  int  owner = 1;
  int  run = 0;
  bit  m_act = 0;
  bit  acc0 = 0, acc1 = 0;
  bit  log_on = 0;
  int  glog[$];

  function automatic logic [31:0] refrd(logic [AW-1:0] a);
    return refm.exists(int'(a)) ? refm[int'(a)] : 32'h0;
  endfunction

  // Request-side checker: predicts the grant, checks stall and RAM
  // drive, and queues the expected read returns.
  always @(negedge clk) begin
    bit r0, r1;
    int g;
    exp_t e;
    if (reset) begin
      owner = 1; run = 0; m_act = 0; acc0 = 0; acc1 = 0;
      exp0.delete(); exp1.delete();
    end else begin
      r0 = m0_read | m0_write;
      r1 = m1_read | m1_write;
      g = -1;
      if (r0 && r1) g = (m_act && run < MH) ? owner : 1 - owner;
      else if (r0) g = 0;
      else if (r1) g = 1;
      chk("wait0", 32'(m0_waitrequest), 32'(r0 && g != 0));
      chk("wait1", 32'(m1_waitrequest), 32'(r1 && g != 1));
      chk("ram_cs", 32'(ram_chipselect), 32'(g >= 0));
      chk("ram_clken", 32'(ram_clken), 32'd1);
      if (g == 0) begin
        chk("ram_wr", 32'(ram_write), 32'(m0_write));
        chk("ram_addr", 32'(ram_address), 32'(m0_address));
        chk("ram_be", 32'(ram_byteenable), 32'(m0_byteenable));
        chk("ram_wd", ram_writedata, m0_writedata);
      end else if (g == 1) begin
        chk("ram_wr", 32'(ram_write), 32'(m1_write));
        chk("ram_addr", 32'(ram_address), 32'(m1_address));
        chk("ram_be", 32'(ram_byteenable), 32'(m1_byteenable));
        chk("ram_wd", ram_writedata, m1_writedata);
      end else begin
        chk("ram_idle", {ram_writedata[27:0], ram_byteenable},
            32'h0);
        chk("ram_idle_a", {16'h0, ram_write, ram_address}, 32'h0);
      end
      if (log_on) glog.push_back(g);
      acc0 = (g == 0);
      acc1 = (g == 1);
      if (g == 0) begin
        if (m0_write) refm[int'(m0_address)] =
          merge(refrd(m0_address), m0_writedata, m0_byteenable);
        else begin
          e.due = cyc + LAT; e.data = refrd(m0_address);
          exp0.push_back(e);
        end
      end else if (g == 1) begin
        if (m1_write) refm[int'(m1_address)] =
          merge(refrd(m1_address), m1_writedata, m1_byteenable);
        else begin
          e.due = cyc + LAT; e.data = refrd(m1_address);
          exp1.push_back(e);
        end
      end
      if (g >= 0) begin
        run = (m_act && g == owner) ? ((run < MH) ? run + 1 : run) : 1;
        owner = g;
        m_act = 1;
      end else begin
        m_act = 0;
        run = 0;
      end
    end
  end

  // Response monitor: every read return must match the queue head.
  always @(negedge clk) begin
    bit e0, e1;
    if (!reset) begin
      e0 = exp0.size() > 0 && exp0[0].due == cyc;
      e1 = exp1.size() > 0 && exp1[0].due == cyc;
      chk("rdv0", 32'(m0_readdatavalid), 32'(e0));
      chk("rdv1", 32'(m1_readdatavalid), 32'(e1));
      if (e0) begin
        if (m0_readdatavalid) chk("rdata0", m0_readdata, exp0[0].data);
        void'(exp0.pop_front());
      end
      if (e1) begin
        if (m1_readdatavalid) chk("rdata1", m1_readdata, exp1[0].data);
        void'(exp1.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
  endtask

  task automatic req(int p, bit rd, bit wr, logic [AW-1:0] a,
                     logic [DW-1:0] d, logic [BW-1:0] be);
    if (p == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a;
      m0_writedata = d; m0_byteenable = be;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a;
      m1_writedata = d; m1_byteenable = be;
    end
  endtask

  // Single read, then wait (bounded) for its return on port p.
  task automatic rd_expect(int p, logic [AW-1:0] a, logic [31:0] v,
                           string nm);
    bit got;
    got = 0;
    req(p, 1, 0, a, '0, 4'hF);
    step();
    idle();
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      #1;
      if (p == 0 && m0_readdatavalid) begin
        got = 1; chk(nm, m0_readdata, v);
      end
      if (p == 1 && m1_readdatavalid) begin
        got = 1; chk(nm, m1_readdata, v);
      end
    end
    if (!got) chk({nm, "_timeout"}, 32'd0, 32'd1);
    step();
  endtask

  initial begin
    int exp_g [12];
    exp_g = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    reset = 1;
    idle();
    m0_address = '0; m1_address = '0;
    m0_byteenable = '0; m1_byteenable = '0;
    m0_writedata = '0; m1_writedata = '0;
    repeat (3) step();
    reset = 0;
    repeat (3) step();

    req(0, 0, 1, 15'h0010, 32'hDEADBEEF, 4'hF);
    step();
    idle();
    rd_expect(1, 15'h0010, 32'hDEADBEEF, "m1_rd_deadbeef");

    step();
    log_on = 1;
    req(0, 1, 0, 15'h0001, '0, 4'hF);
    req(1, 1, 0, 15'h0010, '0, 4'hF);
    repeat (12) step();
    log_on = 0;
    idle();
    step();
    chk("glog_len", 32'(glog.size()), 32'd12);
    for (int i = 0; i < 12 && i < glog.size(); i++)
      chk($sformatf("grant_seq[%0d]", i), 32'(glog[i]), 32'(exp_g[i]));
    glog.delete();

    req(0, 0, 1, 15'h0030, 32'h11223344, 4'hF);
    step();
    req(0, 0, 1, 15'h0030, 32'h000000AA, 4'b0001);
    step();
    idle();
    rd_expect(0, 15'h0030, 32'h112233AA, "byte_en_merge");

    req(0, 1, 1, 15'h0020, 32'h5, 4'hF);
    step();
    idle();
    step();
    rd_expect(0, 15'h0020, 32'h5, "rd_wr_is_write");

    req(1, 1, 0, 15'h0010, '0, 4'hF);
    step();
    idle();
    reset = 1;
    repeat (2) step();
    reset = 0;
    step();
    log_on = 1;
    req(0, 1, 0, 15'h0002, '0, 4'hF);
    req(1, 1, 0, 15'h0003, '0, 4'hF);
    step();
    log_on = 0;
    idle();
    step();
    chk("post_reset_len", 32'(glog.size()), 32'd1);
    if (glog.size() > 0) chk("post_reset_grant", 32'(glog[0]), 32'd0);
    glog.delete();

    for (int n = 0; n < 400; n++) begin
      if (!(m0_read | m0_write) || acc0) begin
        if ($urandom_range(0, 9) < 3) begin
          m0_read = 0; m0_write = 0;
        end else
          req(0, 1'($urandom), 1'($urandom), 15'($urandom_range(0, 15)),
              $urandom, 4'($urandom));
      end
      if (!(m1_read | m1_write) || acc1) begin
        if ($urandom_range(0, 9) < 3) begin
          m1_read = 0; m1_write = 0;
        end else
          req(1, 1'($urandom), 1'($urandom), 15'($urandom_range(0, 15)),
              $urandom, 4'($urandom));
      end
      step();
    end
    idle();
    repeat (4) step();
    chk("drain0", 32'(exp0.size()), 32'd0);
    chk("drain1", 32'(exp1.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
